dicas_jogo: RTL and testbench
=============================

// Module: dicas_jogo
// PURPOSE
//   Sequential hint engine for the guess-the-password game. Latches NUM_SECRETS
//   secrets of WIDTH bits each and walks them in order (secret 0 first).
//   Scores each submitted guess against the current secret and emits a
//   registered less/greater/equal hint for HEX6 and an overall parity hint for HEX7.
//   Tracks remaining tries and ends the game in WON or LOST.
//   Sits between the switch/key input logic and the 7-segment decoders.
// PARAMETERS
//   NUM_SECRETS  2  number of secrets played in sequence (>=1)
//   WIDTH        4  bits per secret and per guess (>=1)
//   MAX_TRIES    7  wrong guesses allowed per game (>=1)
// PORTS
//   clk          in   1                  system clock, rising edge
//   rst_n        in   1                  async active-low reset
//   load         in   1                  1-cycle pulse: latch secret_in, start new game
//   secret_in    in   NUM_SECRETS*WIDTH  secret k at bits [k*WIDTH +: WIDTH]
//   guess_valid  in   1                  1-cycle pulse: guess is valid this cycle
//   guess        in   WIDTH              guess for the current secret
//   paridade     out  1                  XOR of all latched secret bits
//   comp         out  2                  00 guess<secret, 01 guess>secret, 10 equal, 11 no hint
//   hint_valid   out  1                  1-cycle pulse: comp updated this cycle
//   idx          out  clog2(NUM_SECRETS) index of the secret being guessed (1 bit min)
//   tries_left   out  clog2(MAX_TRIES+1) wrong guesses still allowed
//   won          out  1                  level: all secrets found
//   lost         out  1                  level: tries exhausted
// BEHAVIOUR
//   Reset (async, rst_n=0) forces all outputs immediately:
//   state=IDLE, paridade=0, comp=11, hint_valid=0, idx=0, tries_left=MAX_TRIES, won=0, lost=0.
//   Latched secrets reset to 0.
//   FSM states: IDLE, PLAY, WON, LOST.
//   load=1 in any state:
//     - latch secret_in; paridade <= ^secret_in; idx <= 0; tries_left <= MAX_TRIES
//     - comp <= 11; won <= 0; lost <= 0; next state PLAY
//     - load has priority over a guess_valid in the same cycle; that guess is dropped.
//   PLAY, guess_valid=1: compare unsigned guess vs secret[idx].
//     Results are registered; comp and hint_valid appear 1 cycle after guess_valid.
//     equal: comp<=10
//       - idx < NUM_SECRETS-1: idx<=idx+1
//       - idx = last: won<=1, state WON
//       - tries_left unchanged
//     less/greater: comp<=00/01; tries_left<=tries_left-1
//       - if the old tries_left==1: lost<=1, state LOST
//   Guesses arriving back-to-back on consecutive cycles are each scored.
//   guess_valid in IDLE, WON or LOST is ignored (no hint_valid, no counter change).
//   comp holds its last value between hints. idx and tries_left never wrap.
//   won and lost are never both 1. Only load or reset leaves WON or LOST.
//   Async reset during PLAY abandons the game; a new load is needed.
// STRUCTURE
//   Shared package dicas_pkg:
//     - comp encoding constants CMP_MENOR=2'b00, CMP_MAIOR=2'b01, CMP_IGUAL=2'b10, CMP_NONE=2'b11
//     - FSM state typedef
//   Sub-module comparador_dicas (combinational, parametrised WIDTH: a, b -> 2-bit code),
//   instantiated once on the muxed current secret.
//   Top holds the secret register file, FSM, idx and tries counters.
// TESTING
//   Default params:
//     - reset
//     - load secret_in=8'h5A (s0=A, s1=5)
//     - guess 3
//     -> hint_valid 1 cycle later; comp=00, tries_left=6, paridade=0
//   Guess A then 5 -> comp=10 twice; idx 0->1; won=1 after the second hint; tries_left stays 7.
//   7 wrong guesses -> tries_left counts 6..0; lost=1 on the 7th hint; an 8th guess gives no hint_valid.
//   load and guess_valid in the same cycle -> no hint; state PLAY with idx=0 and tries_left=7.
//   rst_n low mid-game -> outputs return to reset values immediately; guesses are ignored until load.
//   NUM_SECRETS=3, WIDTH=6, MAX_TRIES=2 -> equal/greater/less on max value 63 and 0;
//     lost after 2 wrong guesses.

Source files
------------

// File: rtl/dicas_pkg.sv
// Shared definitions for the guess-the-password hint engine: hint encoding and FSM states.
package dicas_pkg;

  localparam logic [1:0] CMP_MENOR = 2'b00;
  localparam logic [1:0] CMP_MAIOR = 2'b01;
  localparam logic [1:0] CMP_IGUAL = 2'b10;
  localparam logic [1:0] CMP_NONE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } estado_t;

endpackage

// File: rtl/dicas_jogo_if.sv
// Bus between the switch/key input logic, the hint engine and the 7-segment decoders.
interface dicas_jogo_if #(
   parameter int NUM_SECRETS = 2,
   parameter int WIDTH       = 4,
   parameter int MAX_TRIES   = 7
);
   import dicas_pkg::*;

   localparam int IDX_W = (NUM_SECRETS > 1) ? $clog2(NUM_SECRETS) : 1;
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   // Pulse protocol, no back-pressure: load and guess_valid are single-cycle strobes that
   // are always accepted (load wins when both are high); hint_valid is a single-cycle strobe
   // one cycle after an accepted guess, and comp holds its value between strobes.
   logic                         load;
   logic [NUM_SECRETS*WIDTH-1:0] secret_in;
   logic                         guess_valid;
   logic [WIDTH-1:0]             guess;
   logic                         paridade;
   logic [1:0]                   comp;
   logic                         hint_valid;
   logic [IDX_W-1:0]             idx;
   logic [TRY_W-1:0]             tries_left;
   logic                         won;
   logic                         lost;
   estado_t                      dbgEstado;

   modport master (
      output load, secret_in, guess_valid, guess,
      input  paridade, comp, hint_valid, idx, tries_left, won, lost, dbgEstado
   );

   modport slave (
      input  load, secret_in, guess_valid, guess,
      output paridade, comp, hint_valid, idx, tries_left, won, lost, dbgEstado
   );

endinterface

// File: rtl/dicas_jogo_comparador.sv
// Unsigned magnitude compare of a guess (a) against a secret (b), encoded as a hint code.
module comparador_dicas #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [1:0]       code
);
   import dicas_pkg::*;

   always_comb begin
      code = CMP_IGUAL;
      if (a < b)      code = CMP_MENOR;
      else if (a > b) code = CMP_MAIOR;
   end

endmodule

// File: rtl/dicas_jogo.sv
// Sequential hint engine: walks the latched secrets in order, scores guesses, counts tries.
module dicas_jogo #(
   parameter int NUM_SECRETS = 2,
   parameter int WIDTH       = 4,
   parameter int MAX_TRIES   = 7
) (
   input logic         clk,
   input logic         rst_n,
   dicas_jogo_if.slave bus
);
   import dicas_pkg::*;

   localparam int IDX_W = (NUM_SECRETS > 1) ? $clog2(NUM_SECRETS) : 1;
   localparam int TRY_W = $clog2(MAX_TRIES + 1);

   logic [WIDTH-1:0] secrets [NUM_SECRETS];
   logic [WIDTH-1:0] secretAtual;
   logic [1:0]       cmpCode;

   estado_t          estado, estadoNext;
   logic [1:0]       comp, compNext;
   logic             hintValid, hintNext;
   logic [IDX_W-1:0] idx, idxNext;
   logic [TRY_W-1:0] tries, triesNext;
   logic             paridade, parNext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_SECRETS; k++) secrets[k] <= '0;
      end else if (bus.load) begin
         for (int k = 0; k < NUM_SECRETS; k++) secrets[k] <= bus.secret_in[k*WIDTH +: WIDTH];
      end
   end

   assign secretAtual = secrets[idx];

   comparador_dicas #(.WIDTH(WIDTH)) u_comparador (
      .a    (bus.guess),
      .b    (secretAtual),
      .code (cmpCode)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado    <= IDLE;
         comp      <= CMP_NONE;
         hintValid <= 1'b0;
         idx       <= '0;
         tries     <= TRY_W'(MAX_TRIES);
         paridade  <= 1'b0;
      end else begin
         estado    <= estadoNext;
         comp      <= compNext;
         hintValid <= hintNext;
         idx       <= idxNext;
         tries     <= triesNext;
         paridade  <= parNext;
      end
   end

   // A guess coinciding with load is dropped: load starts a fresh game.
   always_comb begin
      estadoNext = estado;
      compNext   = comp;
      hintNext   = 1'b0;
      idxNext    = idx;
      triesNext  = tries;
      parNext    = paridade;
      if (bus.load) begin
         estadoNext = PLAY;
         compNext   = CMP_NONE;
         idxNext    = '0;
         triesNext  = TRY_W'(MAX_TRIES);
         parNext    = ^bus.secret_in;
      end else if (estado == PLAY && bus.guess_valid) begin
         hintNext = 1'b1;
         compNext = cmpCode;
         if (cmpCode == CMP_IGUAL) begin
            if (idx == IDX_W'(NUM_SECRETS - 1)) estadoNext = WON;
            else                                 idxNext    = idx + IDX_W'(1);
         end else begin
            triesNext = tries - TRY_W'(1);
            if (tries == TRY_W'(1)) estadoNext = LOST;
         end
      end
   end

   assign bus.paridade   = paridade;
   assign bus.comp       = comp;
   assign bus.hint_valid = hintValid;
   assign bus.idx        = idx;
   assign bus.tries_left = tries;
   assign bus.won        = (estado == WON);
   assign bus.lost       = (estado == LOST);
   assign bus.dbgEstado  = estado;

endmodule

// File: tb/tb_dicas_jogo.sv
// Bench for dicas_jogo: default configuration plus a 3x6-bit, 2-try configuration.
module tb_dicas_jogo;
  import dicas_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [1:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dicas_jogo_if #(.NUM_SECRETS(2), .WIDTH(4), .MAX_TRIES(7)) if_a ();
  dicas_jogo_if #(.NUM_SECRETS(3), .WIDTH(6), .MAX_TRIES(2)) if_b ();

  dicas_jogo #(.NUM_SECRETS(2), .WIDTH(4), .MAX_TRIES(7)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  dicas_jogo #(.NUM_SECRETS(3), .WIDTH(6), .MAX_TRIES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );

  typedef struct {
    logic       ld;
    logic [7:0] sec;
    logic       gv;
    logic [3:0] g;
    logic [1:0] comp;
    logic       hv;
    logic [0:0] idx;
    logic [2:0] tries;
    logic       won;
    logic       lost;
    logic       par;
    estado_t    st;
  } vec_a_t;

  typedef struct {
    logic        ld;
    logic [17:0] sec;
    logic        gv;
    logic [5:0]  g;
    logic [1:0]  comp;
    logic        hv;
    logic [1:0]  idx;
    logic [1:0]  tries;
    logic        won;
    logic        lost;
    logic        par;
    estado_t     st;
  } vec_b_t;

  vec_a_t tab_a[23];
  vec_b_t tab_b[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: pop one expected hint per observed hint_valid
  task automatic score_hint(input string tag, input logic hv, input logic [1:0] comp, input logic exp_hv);
    logic [1:0] e;
    chk({tag, " hint_valid"}, hv, exp_hv);
    if (hv) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s unexpected_hint: got comp %0h expected no hint", tag, comp);
      end else begin
        e = exp_q.pop_front();
        chk({tag, " hint_comp"}, comp, e);
      end
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s missing_hint: got none expected %0d pending", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_a(input int i);
    vec_a_t v;
    string  t;
    v = tab_a[i];
    t = $sformatf("A[%0d]", i);
    if_a.load = v.ld; if_a.secret_in = v.sec; if_a.guess_valid = v.gv; if_a.guess = v.g;
    if (v.hv) exp_q.push_back(v.comp);
    @(posedge clk);
    #1;
    if_a.load = 1'b0; if_a.guess_valid = 1'b0;
    score_hint(t, if_a.hint_valid, if_a.comp, v.hv);
    chk({t, " comp"}, if_a.comp, v.comp);
    chk({t, " idx"}, if_a.idx, v.idx);
    chk({t, " tries_left"}, if_a.tries_left, v.tries);
    chk({t, " won"}, if_a.won, v.won);
    chk({t, " lost"}, if_a.lost, v.lost);
    chk({t, " paridade"}, if_a.paridade, v.par);
    chk({t, " state"}, if_a.dbgEstado, v.st);
  endtask

  task automatic apply_b(input int i);
    vec_b_t v;
    string  t;
    v = tab_b[i];
    t = $sformatf("B[%0d]", i);
    if_b.load = v.ld; if_b.secret_in = v.sec; if_b.guess_valid = v.gv; if_b.guess = v.g;
    if (v.hv) exp_q.push_back(v.comp);
    @(posedge clk);
    #1;
    if_b.load = 1'b0; if_b.guess_valid = 1'b0;
    score_hint(t, if_b.hint_valid, if_b.comp, v.hv);
    chk({t, " comp"}, if_b.comp, v.comp);
    chk({t, " idx"}, if_b.idx, v.idx);
    chk({t, " tries_left"}, if_b.tries_left, v.tries);
    chk({t, " won"}, if_b.won, v.won);
    chk({t, " lost"}, if_b.lost, v.lost);
    chk({t, " paridade"}, if_b.paridade, v.par);
    chk({t, " state"}, if_b.dbgEstado, v.st);
  endtask

  task automatic chk_reset_a(input string t);
    chk({t, " comp"}, if_a.comp, 2'b11);
    chk({t, " hint_valid"}, if_a.hint_valid, 1'b0);
    chk({t, " idx"}, if_a.idx, 1'b0);
    chk({t, " tries_left"}, if_a.tries_left, 3'd7);
    chk({t, " won"}, if_a.won, 1'b0);
    chk({t, " lost"}, if_a.lost, 1'b0);
    chk({t, " paridade"}, if_a.paridade, 1'b0);
    chk({t, " state"}, if_a.dbgEstado, IDLE);
  endtask

  initial begin
    logic [17:0] sb;
    sb = {6'd21, 6'd0, 6'd63};

    //            ld  sec    gv g     comp  hv idx tries won lost par st
    tab_a[0]  = '{0, 8'h00, 1, 4'h3, 2'b11, 0, 0, 3'd7, 0, 0, 0, IDLE};
    tab_a[1]  = '{1, 8'h5A, 0, 4'h0, 2'b11, 0, 0, 3'd7, 0, 0, 0, PLAY};
    tab_a[2]  = '{0, 8'h5A, 1, 4'h3, 2'b00, 1, 0, 3'd6, 0, 0, 0, PLAY};
    tab_a[3]  = '{0, 8'h5A, 0, 4'h0, 2'b00, 0, 0, 3'd6, 0, 0, 0, PLAY};
    tab_a[4]  = '{0, 8'h5A, 1, 4'hB, 2'b01, 1, 0, 3'd5, 0, 0, 0, PLAY};
    tab_a[5]  = '{1, 8'h5A, 0, 4'h0, 2'b11, 0, 0, 3'd7, 0, 0, 0, PLAY};
    tab_a[6]  = '{0, 8'h5A, 1, 4'hA, 2'b10, 1, 1, 3'd7, 0, 0, 0, PLAY};
    tab_a[7]  = '{0, 8'h5A, 1, 4'h5, 2'b10, 1, 1, 3'd7, 1, 0, 0, WON};
    tab_a[8]  = '{0, 8'h5A, 1, 4'h5, 2'b10, 0, 1, 3'd7, 1, 0, 0, WON};
    tab_a[9]  = '{1, 8'h5A, 1, 4'hA, 2'b11, 0, 0, 3'd7, 0, 0, 0, PLAY};
    for (int k = 0; k < 7; k++)
      tab_a[10+k] = '{0, 8'h5A, 1, 4'h0, 2'b00, 1, 0, 3'(6-k), 0, (k == 6), 0,
                      (k == 6) ? LOST : PLAY};
    tab_a[17] = '{0, 8'h5A, 1, 4'h0, 2'b00, 0, 0, 3'd0, 0, 1, 0, LOST};
    tab_a[18] = '{1, 8'h5B, 0, 4'h0, 2'b11, 0, 0, 3'd7, 0, 0, 1, PLAY};
    tab_a[19] = '{0, 8'h5B, 1, 4'hF, 2'b01, 1, 0, 3'd6, 0, 0, 1, PLAY};
    tab_a[20] = '{0, 8'h00, 1, 4'h3, 2'b11, 0, 0, 3'd7, 0, 0, 0, IDLE};
    tab_a[21] = '{1, 8'h5A, 0, 4'h0, 2'b11, 0, 0, 3'd7, 0, 0, 0, PLAY};
    tab_a[22] = '{0, 8'h5A, 1, 4'hA, 2'b10, 1, 1, 3'd7, 0, 0, 0, PLAY};

    tab_b[0]  = '{1, sb, 0, 6'd0,  2'b11, 0, 2'd0, 2'd2, 0, 0, 1, PLAY};
    tab_b[1]  = '{0, sb, 1, 6'd63, 2'b10, 1, 2'd1, 2'd2, 0, 0, 1, PLAY};
    tab_b[2]  = '{0, sb, 1, 6'd0,  2'b10, 1, 2'd2, 2'd2, 0, 0, 1, PLAY};
    tab_b[3]  = '{0, sb, 1, 6'd63, 2'b01, 1, 2'd2, 2'd1, 0, 0, 1, PLAY};
    tab_b[4]  = '{0, sb, 1, 6'd0,  2'b00, 1, 2'd2, 2'd0, 0, 1, 1, LOST};
    tab_b[5]  = '{0, sb, 1, 6'd21, 2'b00, 0, 2'd2, 2'd0, 0, 1, 1, LOST};
    tab_b[6]  = '{1, sb, 0, 6'd0,  2'b11, 0, 2'd0, 2'd2, 0, 0, 1, PLAY};
    tab_b[7]  = '{0, sb, 1, 6'd62, 2'b00, 1, 2'd0, 2'd1, 0, 0, 1, PLAY};
    tab_b[8]  = '{0, sb, 1, 6'd63, 2'b10, 1, 2'd1, 2'd1, 0, 0, 1, PLAY};
    tab_b[9]  = '{0, sb, 1, 6'd1,  2'b01, 1, 2'd1, 2'd0, 0, 1, 1, LOST};

    if_a.load = 1'b0; if_a.secret_in = '0; if_a.guess_valid = 1'b0; if_a.guess = '0;
    if_b.load = 1'b0; if_b.secret_in = '0; if_b.guess_valid = 1'b0; if_b.guess = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk_reset_a("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) apply_a(i);

    // asynchronous reset mid-game must clear outputs before any clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_a("midgame_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 20; i < 23; i++) apply_a(i);

    for (int i = 0; i < 10; i++) apply_b(i);

    // random back-to-back wrong guesses on config A: each one must be scored
    apply_a(21);
    for (int k = 0; k < 4; k++) begin
      vec_a_t v;
      v = '{0, 8'h5A, 1, 4'($urandom_range(0, 9)), 2'b00, 1, 0, 3'(6-k), 0, 0, 0, PLAY};
      tab_a[0] = v;
      apply_a(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
